// File: rtl/generic_dual_port_ram_ctrl.sv
// True dual-port RAM controller: single clock, req/ready handshake per port,
// deterministic cross-port collision handling, per-read valid strobes and a
// clear engine that sweeps every word to CLR_VALUE.
module generic_dual_port_ram_ctrl #(
  parameter int unsigned    Dw           = 32,
  parameter int unsigned    Aw           = 8,
  parameter int unsigned    BYTE_W       = 8,
  parameter int unsigned    RD_LAT       = 1,
  parameter string          RDW_MODE     = "NEW_DATA",
  parameter string          CLR_ON_RESET = "YES",
  parameter logic [Dw-1:0]  CLR_VALUE    = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr_req,
  output logic                 busy,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [Aw-1:0]        a_addr,
  input  logic [Dw/BYTE_W-1:0] a_byteen,
  input  logic [Dw-1:0]        a_data,
  output logic                 a_ready,
  output logic                 a_rd_valid,
  output logic [Dw-1:0]        a_q,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [Aw-1:0]        b_addr,
  input  logic [Dw/BYTE_W-1:0] b_byteen,
  input  logic [Dw-1:0]        b_data,
  output logic                 b_ready,
  output logic                 b_rd_valid,
  output logic [Dw-1:0]        b_q
);

  localparam int unsigned BEw      = Dw / BYTE_W;
  localparam int unsigned DEPTH    = 2 ** Aw;
  localparam bit          NEW_DATA = (RDW_MODE == "NEW_DATA");
  localparam bit          CLR_RST  = (CLR_ON_RESET == "YES");

  typedef enum logic {ST_RUN, ST_CLEAR} state_t;

  state_t          state, state_n;
  logic [Aw-1:0]   cnt, cnt_n;
  logic            clearing, run;

  logic [Dw-1:0]   mem [DEPTH];

  // Index 0 is port A, index 1 is port B.
  logic [Aw-1:0]   addr  [2];
  logic [BEw-1:0]  ben   [2];
  logic [Dw-1:0]   wdata [2];
  logic [Dw-1:0]   rword [2];
  logic [1:0]      acc_rd, acc_wr;

  logic [1:0]      v1, v2;
  logic [Dw-1:0]   d1 [2];
  logic [Dw-1:0]   d2 [2];

  assign addr[0]  = a_addr;
  assign addr[1]  = b_addr;
  assign ben[0]   = a_byteen;
  assign ben[1]   = b_byteen;
  assign wdata[0] = a_data;
  assign wdata[1] = b_data;

  assign clearing = (state == ST_CLEAR);
  assign run      = (state == ST_RUN) && !reset;
  assign busy     = clearing;
  assign a_ready  = run;
  assign b_ready  = run;

  assign acc_rd = {b_req & ~b_we, a_req & ~a_we} & {2{run}};
  assign acc_wr = {b_req &  b_we, a_req &  a_we} & {2{run}};

  // State and sweep address register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CLR_RST ? ST_CLEAR : ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state: a sweep covers every address once, clr_req only starts one from RUN.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      ST_RUN: begin
        if (clr_req) begin
          state_n = ST_CLEAR;
          cnt_n   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_n = cnt + 1'b1;
        if (cnt == '1) state_n = ST_RUN;
      end
      default: state_n = ST_RUN;
    endcase
  end

  // Read word per port; with NEW_DATA the other port's same-cycle write is merged in.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      rword[p] = mem[addr[p]];
      if (NEW_DATA && acc_wr[1-p] && (addr[1-p] == addr[p])) begin
        for (int unsigned i = 0; i < BEw; i++) begin
          if (ben[1-p][i]) rword[p][i*BYTE_W +: BYTE_W] = wdata[1-p][i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Array write: B lanes are issued before A lanes so A wins overlapping lanes.
  always_ff @(posedge clk) begin
    if (clearing && !reset) begin
      mem[cnt] <= CLR_VALUE;
    end else begin
      for (int unsigned i = 0; i < BEw; i++) begin
        if (acc_wr[1] && ben[1][i]) mem[addr[1]][i*BYTE_W +: BYTE_W] <= wdata[1][i*BYTE_W +: BYTE_W];
      end
      for (int unsigned i = 0; i < BEw; i++) begin
        if (acc_wr[0] && ben[0][i]) mem[addr[0]][i*BYTE_W +: BYTE_W] <= wdata[0][i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Read pipeline: data registers only load on a valid read, so q holds between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1 <= '0;
      v2 <= '0;
      for (int unsigned p = 0; p < 2; p++) begin
        d1[p] <= '0;
        d2[p] <= '0;
      end
    end else begin
      v1 <= acc_rd;
      v2 <= v1;
      for (int unsigned p = 0; p < 2; p++) begin
        if (acc_rd[p]) d1[p] <= rword[p];
        if (v1[p])     d2[p] <= d1[p];
      end
    end
  end

  assign a_rd_valid = (RD_LAT == 2) ? v2[0] : v1[0];
  assign b_rd_valid = (RD_LAT == 2) ? v2[1] : v1[1];
  assign a_q        = (RD_LAT == 2) ? d2[0] : d1[0];
  assign b_q        = (RD_LAT == 2) ? d2[1] : d1[1];

endmodule

// File: tb/tb_generic_dual_port_ram_ctrl.sv
// Bench for generic_dual_port_ram_ctrl: two instances share stimulus,
// one RD_LAT=2/NEW_DATA, one RD_LAT=1/OLD_DATA, both with a 16-word array.
module tb_generic_dual_port_ram_ctrl;

  localparam logic [31:0] CLRV = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clr_req = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [3:0]  a_addr = '0, a_byteen = '0, b_addr = '0, b_byteen = '0;
  logic [31:0] a_data = '0, b_data = '0;

  logic        busy_o [2];
  logic [1:0]  rdy_o  [2];
  logic [1:0]  rv_o   [2];
  logic [31:0] q_o    [2][2];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  generic_dual_port_ram_ctrl #(
    .Dw(32), .Aw(4), .BYTE_W(8), .RD_LAT(2), .RDW_MODE("NEW_DATA"),
    .CLR_ON_RESET("YES"), .CLR_VALUE(CLRV)
  ) dut_n (
    .clk(clk), .reset(reset), .clr_req(clr_req), .busy(busy_o[0]),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_byteen(a_byteen), .a_data(a_data),
    .a_ready(rdy_o[0][0]), .a_rd_valid(rv_o[0][0]), .a_q(q_o[0][0]),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_byteen(b_byteen), .b_data(b_data),
    .b_ready(rdy_o[0][1]), .b_rd_valid(rv_o[0][1]), .b_q(q_o[0][1])
  );

  generic_dual_port_ram_ctrl #(
    .Dw(32), .Aw(4), .BYTE_W(8), .RD_LAT(1), .RDW_MODE("OLD_DATA"),
    .CLR_ON_RESET("YES"), .CLR_VALUE(CLRV)
  ) dut_o (
    .clk(clk), .reset(reset), .clr_req(clr_req), .busy(busy_o[1]),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_byteen(a_byteen), .a_data(a_data),
    .a_ready(rdy_o[1][0]), .a_rd_valid(rv_o[1][0]), .a_q(q_o[1][0]),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_byteen(b_byteen), .b_data(b_data),
    .b_ready(rdy_o[1][1]), .b_rd_valid(rv_o[1][1]), .b_q(q_o[1][1])
  );

  // Reference model: word array, remaining sweep cycles, and expected read
  // deliveries scheduled by absolute edge number (slot = edge mod 4).
  logic [31:0] mmem [16];
  int          clr_left = 16;
  int          edge_n = 0;
  bit          ev [2][2][4];
  logic [31:0] ed [2][2][4];
  logic [31:0] lastq [2][2];

  function automatic int lat(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = nd[i*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int  slot;
    bit  xv;
    slot = edge_n % 4;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("busy[d%0d]", d), {31'b0, busy_o[d]}, {31'b0, clr_left != 0});
      chk($sformatf("ready[d%0d]", d), {30'b0, rdy_o[d]}, (clr_left == 0) ? 32'd3 : 32'd0);
      for (int p = 0; p < 2; p++) begin
        xv = ev[d][p][slot];
        if (xv) begin
          lastq[d][p] = ed[d][p][slot];
          ev[d][p][slot] = 1'b0;
        end
        chk($sformatf("rd_valid[d%0d p%0d]", d, p), {31'b0, rv_o[d][p]}, {31'b0, xv});
        chk($sformatf("q[d%0d p%0d]", d, p), q_o[d][p], lastq[d][p]);
      end
    end
  endtask

  task automatic step(input bit clr,
                      input bit ar, input bit aw, input logic [3:0] aa, input logic [3:0] ab,
                      input logic [31:0] ad,
                      input bit br, input bit bw, input logic [3:0] ba, input logic [3:0] bb,
                      input logic [31:0] bd);
    bit          rdy, ar_acc, aw_acc, br_acc, bw_acc;
    logic [31:0] old_a, old_b, new_a, new_b;
    int          slot;
    clr_req = clr;
    a_req = ar; a_we = aw; a_addr = aa; a_byteen = ab; a_data = ad;
    b_req = br; b_we = bw; b_addr = ba; b_byteen = bb; b_data = bd;
    rdy    = (clr_left == 0);
    ar_acc = ar && !aw && rdy;
    aw_acc = ar &&  aw && rdy;
    br_acc = br && !bw && rdy;
    bw_acc = br &&  bw && rdy;
    old_a = mmem[aa];
    old_b = mmem[ba];
    new_a = (bw_acc && ba == aa) ? merge(old_a, bd, bb) : old_a;
    new_b = (aw_acc && aa == ba) ? merge(old_b, ad, ab) : old_b;
    for (int d = 0; d < 2; d++) begin
      slot = (edge_n + lat(d)) % 4;
      if (ar_acc) begin ev[d][0][slot] = 1'b1; ed[d][0][slot] = (d == 0) ? new_a : old_a; end
      if (br_acc) begin ev[d][1][slot] = 1'b1; ed[d][1][slot] = (d == 0) ? new_b : old_b; end
    end
    if (clr_left > 0) begin
      mmem[16 - clr_left] = CLRV;
      clr_left--;
    end else begin
      if (bw_acc) mmem[ba] = merge(mmem[ba], bd, bb);
      if (aw_acc) mmem[aa] = merge(mmem[aa], ad, ab);
      if (clr) clr_left = 16;
    end
    @(posedge clk);
    edge_n++;
    #1;
    check_outputs();
  endtask

  task automatic idle();
    step(0, 0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
  endtask

  task automatic rand_step(input bit allow_clr);
    logic [3:0] aa, ba;
    aa = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
    ba = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
    step(allow_clr && ($urandom_range(0, 49) == 0),
         1'($urandom), 1'($urandom), aa, 4'($urandom), $urandom,
         1'($urandom), 1'($urandom), ba, 4'($urandom), $urandom);
  endtask

  // Asynchronous reset pulse; checks reset values while asserted.
  task automatic do_reset();
    clr_req = 0; a_req = 0; b_req = 0;
    reset = 1'b1;
    clr_left = 16;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        lastq[d][p] = '0;
        for (int s = 0; s < 4; s++) ev[d][p][s] = 1'b0;
      end
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_busy[d%0d]", d), {31'b0, busy_o[d]}, 32'd1);
      chk($sformatf("rst_ready[d%0d]", d), {30'b0, rdy_o[d]}, 32'd0);
      chk($sformatf("rst_valid[d%0d]", d), {30'b0, rv_o[d]}, 32'd0);
      chk($sformatf("rst_qa[d%0d]", d), q_o[d][0], 32'd0);
      chk($sformatf("rst_qb[d%0d]", d), q_o[d][1], 32'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Counts busy cycles from now until busy drops (bounded), then compares.
  task automatic sweep_wait(input int exp_len, input string nm);
    int n0, n1;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy_o[0]) n0++;
      if (busy_o[1]) n1++;
      if (!busy_o[0] && !busy_o[1]) break;
      idle();
    end
    chk({nm, "_len_d0"}, n0, exp_len);
    chk({nm, "_len_d1"}, n1, exp_len);
  endtask

  typedef struct {
    bit ar; bit aw; logic [3:0] aa; logic [3:0] ab; logic [31:0] ad;
    bit br; bit bw; logic [3:0] ba; logic [3:0] bb; logic [31:0] bd;
    bit ca; logic [31:0] ea_new; logic [31:0] ea_old;
    bit cb; logic [31:0] eb_new; logic [31:0] eb_old;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    tbl[0] = '{1, 1, 4'd3, 4'hF, 32'h00000000, 0, 0, 4'd0, 4'h0, 32'h0, 0, '0, '0, 0, '0, '0};
    tbl[1] = '{1, 1, 4'd7, 4'hF, 32'h12345678, 0, 0, 4'd0, 4'h0, 32'h0, 0, '0, '0, 0, '0, '0};
    tbl[2] = '{1, 1, 4'd3, 4'h3, 32'hAAAAAAAA, 1, 1, 4'd3, 4'h6, 32'hBBBBBBBB,
               0, '0, '0, 0, '0, '0};
    tbl[3] = '{1, 1, 4'd7, 4'hF, 32'hFFFFFFFF, 1, 0, 4'd7, 4'h0, 32'h0,
               0, '0, '0, 1, 32'hFFFFFFFF, 32'h12345678};
    tbl[4] = '{0, 0, 4'd0, 4'h0, 32'h0, 1, 0, 4'd3, 4'h0, 32'h0,
               0, '0, '0, 1, 32'h00BBAAAA, 32'h00BBAAAA};
    tbl[5] = '{1, 0, 4'd7, 4'h0, 32'h0, 1, 0, 4'd7, 4'h0, 32'h0,
               1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[6] = '{1, 1, 4'd0, 4'hA, 32'h55667788, 0, 0, 4'd0, 4'h0, 32'h0, 0, '0, '0, 0, '0, '0};
    tbl[7] = '{1, 0, 4'd0, 4'h0, 32'h0, 1, 1, 4'd0, 4'h5, 32'h01020304,
               1, 32'h55027704, 32'h55AD77EF, 0, '0, '0};
    tbl[8] = '{0, 0, 4'd0, 4'h0, 32'h0, 1, 0, 4'd0, 4'h0, 32'h0,
               0, '0, '0, 1, 32'h55027704, 32'h55027704};

    for (int i = 0; i < 16; i++) mmem[i] = 'x;

    @(posedge clk);
    #1;
    do_reset();
    sweep_wait(16, "init_sweep");

    // Back-to-back readback of the cleared array on both ports.
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 4'(i), 4'h0, '0, 1, 0, 4'(15 - i), 4'h0, '0);
      chk($sformatf("init_rd_a[%0d]", i), q_o[1][0], CLRV);
      chk($sformatf("init_rd_b[%0d]", i), q_o[1][1], CLRV);
    end
    idle(); idle();

    // Directed collision table.
    for (int r = 0; r < 9; r++) begin
      step(0, tbl[r].ar, tbl[r].aw, tbl[r].aa, tbl[r].ab, tbl[r].ad,
              tbl[r].br, tbl[r].bw, tbl[r].ba, tbl[r].bb, tbl[r].bd);
      idle(); idle();
      if (tbl[r].ca) begin
        chk($sformatf("tbl%0d_aq_new", r), q_o[0][0], tbl[r].ea_new);
        chk($sformatf("tbl%0d_aq_old", r), q_o[1][0], tbl[r].ea_old);
      end
      if (tbl[r].cb) begin
        chk($sformatf("tbl%0d_bq_new", r), q_o[0][1], tbl[r].eb_new);
        chk($sformatf("tbl%0d_bq_old", r), q_o[1][1], tbl[r].eb_old);
      end
    end

    // Write then read next cycle: latency 1 vs latency 2 pulse position.
    step(0, 1, 1, 4'd5, 4'hF, 32'h11223344, 0, 0, '0, '0, '0);
    step(0, 1, 0, 4'd5, 4'h0, '0, 0, 0, '0, '0, '0);
    chk("lat1_valid_e1", {31'b0, rv_o[1][0]}, 32'd1);
    chk("lat1_q_e1", q_o[1][0], 32'h11223344);
    chk("lat2_valid_e1", {31'b0, rv_o[0][0]}, 32'd0);
    idle();
    chk("lat1_valid_e2", {31'b0, rv_o[1][0]}, 32'd0);
    chk("lat2_valid_e2", {31'b0, rv_o[0][0]}, 32'd1);
    chk("lat2_q_e2", q_o[0][0], 32'h11223344);
    idle();

    // clr_req together with an accepted read; B request during the sweep is dropped.
    step(0, 1, 1, 4'd2, 4'hF, 32'hCAFEF00D, 0, 0, '0, '0, '0);
    step(1, 1, 0, 4'd2, 4'h0, '0, 0, 0, '0, '0, '0);
    chk("clr_busy_rise", {31'b0, busy_o[0]}, 32'd1);
    step(0, 0, 0, '0, '0, '0, 1, 0, 4'd2, 4'h0, '0);
    chk("clr_rd_q_new", q_o[0][0], 32'hCAFEF00D);
    chk("clr_rd_q_old", q_o[1][0], 32'hCAFEF00D);
    chk("clr_b_dropped", {30'b0, rv_o[0][1], rv_o[1][1]}, 32'd0);
    sweep_wait(15, "clr_sweep");

    // Randomized traffic including occasional clear requests.
    for (int i = 0; i < 400; i++) rand_step(1'b1);
    for (int i = 0; i < 20 && clr_left != 0; i++) idle();
    idle(); idle();

    // Reset mid-sweep at address 9: sweep restarts from 0 for a full length.
    step(0, 1, 1, 4'd12, 4'hF, 32'h0BADC0DE, 0, 0, '0, '0, '0);
    step(1, 0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
    for (int i = 0; i < 9; i++) idle();
    do_reset();
    sweep_wait(16, "rst_sweep");
    step(0, 1, 0, 4'd12, 4'h0, '0, 1, 0, 4'd15, 4'h0, '0);
    chk("rst_rd12", q_o[1][0], CLRV);
    chk("rst_rd15", q_o[1][1], CLRV);

    for (int i = 0; i < 60; i++) rand_step(1'b0);
    idle(); idle(); idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/generic_dual_port_ram_ctrl.md
Name: generic_dual_port_ram_ctrl

Overview:
Next-generation true dual-port RAM with a single clock and a request/ready handshake per port.
- Generalises data width, byte-lane width and read latency.
- Adds defined cross-port collision behaviour, per-read valid strobes and a hardware clear engine that sweeps the array to a constant.
- Sits between NoC/processor-side masters and on-chip memory; replaces bare RAM instances where deterministic collision handling and clearing are needed.

Parameters:
- Dw, 32, data width in bits; must be a multiple of BYTE_W.
- Aw, 8, address width; depth = 2**Aw.
- BYTE_W, 8, byte-lane width; BEw = Dw/BYTE_W.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2 (2 adds an output register).
- RDW_MODE, "NEW_DATA", cross-port read-during-write result; "NEW_DATA" or "OLD_DATA".
- CLR_ON_RESET, "YES", run a clear sweep automatically after reset release; "YES" or "NO".
- CLR_VALUE, 0, Dw-bit value written to every word by a clear.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- clr_req  in  1  single-cycle request to start a clear sweep.
- busy  out  1  high while a clear sweep is in progress.
- a_req  in  1  port A access request.
- a_we  in  1  port A: 1 = write, 0 = read.
- a_addr  in  Aw  port A address.
- a_byteen  in  BEw  port A write byte enables.
- a_data  in  Dw  port A write data.
- a_ready  out  1  port A can accept an access this cycle.
- a_rd_valid  out  1  port A read data valid.
- a_q  out  Dw  port A read data.
- b_req, b_we, b_addr, b_byteen, b_data, b_ready, b_rd_valid, b_q: identical to port A, for port B.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values:
  - busy = 1 if CLR_ON_RESET = "YES", else 0.
  - a_ready = b_ready = 0 while reset is asserted.
  - rd_valid = 0 and q = 0 on both ports.
  - Clear address counter = 0.
  - Array contents are not reset.
- FSM states:
  - CLEAR: write CLR_VALUE to address cnt; cnt increments each cycle. When cnt = 2**Aw-1 is written, go to RUN; busy falls on the next cycle. The sweep takes exactly 2**Aw cycles.
  - RUN: ready = 1 on both ports; busy = 0.
- FSM transitions:
  - Reset release goes to CLEAR if CLR_ON_RESET = "YES", otherwise to RUN.
  - clr_req in RUN goes to CLEAR with cnt = 0.
  - clr_req while in CLEAR is ignored; no restart.
  - Reset asserted mid-sweep aborts the sweep; it restarts from address 0 after release if CLR_ON_RESET = "YES".
- Handshake:
  - An access is accepted when req && ready.
  - ready is low for the whole CLEAR state; a req while ready is low is dropped, not queued.
- Simultaneous clr_req and access: the access in the same cycle is accepted (ready = 1); CLEAR begins the next cycle.
- Reads:
  - An accepted read returns data with rd_valid = 1 for exactly one cycle, RD_LAT cycles after acceptance.
  - q holds its last value when rd_valid = 0.
  - Back-to-back reads give one result per cycle (full throughput).
  - Reads already in flight complete normally even if CLEAR has started.
- Writes:
  - Only bytes with byteen[i] = 1 are updated.
  - Writes never raise rd_valid.
- Cross-port collisions (same address, same cycle):
  - Write/write: port A wins on overlapping byte lanes; port B's non-overlapping enabled lanes are still written.
  - Read/write: with "NEW_DATA", the reader sees merged data (written bytes new, others old); with "OLD_DATA", the reader sees the pre-write word.
  - Read/read: both ports return the same word.
- Address range: addresses are Aw bits wide and cover the full depth, so there is no wrap or range error.

Test Plan:
- Dw=32, Aw=4, CLR_ON_RESET="YES", CLR_VALUE=32'hDEADBEEF: release reset -> busy=1, ready=0 for exactly 16 cycles; then reads of addr 0..15 all return 32'hDEADBEEF.
- RD_LAT=2: A writes 32'h11223344 to addr 5 with byteen 4'b1111; the next cycle A reads addr 5 -> a_rd_valid pulses 2 cycles after acceptance with a_q=32'h11223344. With RD_LAT=1 the pulse comes 1 cycle after acceptance.
- Addr 3 = 32'h00000000: same cycle, A writes 32'hAAAAAAAA with byteen 4'b0011 and B writes 32'hBBBBBBBB with byteen 4'b0110 -> later read returns 32'h00BBAAAA.
- Addr 7 = 32'h12345678: same cycle, A writes 32'hFFFFFFFF with byteen 4'b1111 and B reads addr 7 -> b_q=32'hFFFFFFFF under "NEW_DATA", 32'h12345678 under "OLD_DATA".
- In RUN, pulse clr_req together with an accepted A read of addr 2 -> the read completes with valid data; busy rises next cycle; a B request during the sweep is ignored and yields no rd_valid.
- Assert reset at sweep address 9, release -> sweep restarts at 0 and busy stays high for a full 16 cycles after release.
